cic_decim_sequencer: RTL
========================

Name: cic_decim_sequencer

Overview:
- Timing controller for the 1-bit SDR CIC decimator chain.
- Counts input sample strobes and generates the clock-enable for the integrator stages (o_int_ce) and the decimated clock-enable for the comb stages (o_comb_ce).
- Applies run-time decimation-ratio changes only at decimation boundaries.
- Suppresses output-valid until the comb pipeline has flushed after enable or a ratio change.

Parameters:
- RW, 12, width of decimation ratio and counter.
- N_STAGES, 3, number of comb stages, which sets the warm-up length in decimated outputs.
- DEFAULT_RATIO, 64, decimation ratio after reset; must be >= 2.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  run control; low holds the chain idle.
- i_sample_valid  in  1  one-cycle strobe per input sample.
- i_ratio  in  RW  requested decimation ratio.
- i_ratio_load  in  1  one-cycle strobe that captures i_ratio.
- o_int_ce  out  1  integrator clock-enable.
- o_comb_ce  out  1  comb/decimator clock-enable.
- o_out_valid  out  1  decimated output sample is valid.
- o_ratio_active  out  RW  ratio currently in use.
- o_ratio_err  out  1  one-cycle pulse when a load is rejected.
- o_running  out  1  high in RUN state.

Behaviour:
- Reset is asynchronous and active-high on i_reset; clock is i_clk.
- Reset values:
  - state = IDLE; dec_cnt = 0; warm_cnt = N_STAGES; pending flag = 0.
  - o_ratio_active = DEFAULT_RATIO.
  - o_int_ce, o_comb_ce, o_out_valid, o_ratio_err, o_running = 0.
- States:
  - IDLE: no enables issued.
  - WARM: enables issued, o_out_valid suppressed.
  - RUN: enables issued, o_out_valid asserted on each decimated output.
- Transitions:
  - IDLE -> WARM when i_enable = 1. Entry sets warm_cnt = N_STAGES and dec_cnt = 0; any pending ratio is applied.
  - WARM -> RUN on the cycle o_comb_ce is issued with warm_cnt = 1.
  - Any state -> IDLE when i_enable = 0, in the next cycle. This clears dec_cnt and all strobes. A pending ratio is retained.
- Accepted sample: i_sample_valid = 1 while state is not IDLE.
  - o_int_ce = 1 in the following cycle; latency is 1 cycle.
  - dec_cnt increments on each accepted sample.
  - When dec_cnt == o_ratio_active-1: dec_cnt wraps to 0 and o_comb_ce = 1 in the same cycle as that o_int_ce.
  - In WARM, each o_comb_ce decrements warm_cnt.
- o_out_valid = registered copy of o_comb_ce, gated by RUN, i.e. 2 cycles after the boundary sample strobe.
  - The comb_ce that causes WARM -> RUN does not raise o_out_valid.
  - The first valid output is the (N_STAGES+1)th comb_ce.
- Ratio load:
  - i_ratio < 2 rejects the load: o_ratio_err pulses next cycle; pending is unchanged.
  - Otherwise i_ratio is stored as pending. A second load before it is applied overwrites it.
  - In IDLE, pending is applied immediately on the next cycle.
  - Otherwise pending is applied at the cycle of the next wrap: o_ratio_active updates, state -> WARM, warm_cnt = N_STAGES. That wrap's comb_ce still counts under the old ratio and does not decrement the new warm_cnt.
  - Load in the same cycle as a wrap: that wrap uses the old ratio; the new ratio applies at the following wrap.
- i_sample_valid in IDLE is ignored with no side effects.
- Back-to-back strobes every cycle must be supported: ratio 2 gives o_comb_ce on every second o_int_ce.
- Reset mid-operation: immediate return to reset values. Pending is discarded and o_ratio_active reverts to DEFAULT_RATIO.

Test Plan:
- Reset, i_enable = 1, strobe every cycle, default ratio 64, N_STAGES 3:
  - o_int_ce follows each strobe by 1 cycle.
  - o_comb_ce on samples 64, 128, 192, 256.
  - o_out_valid first 1 cycle after the 256th-sample comb_ce, and then every 64 samples.
- Load ratio 8 mid-frame at sample 100 of ratio 64:
  - o_ratio_active stays 64 until the wrap at sample 128, then becomes 8.
  - Next comb_ce at sample 136; o_out_valid resumes at the comb_ce of sample 160.
- Load ratio 1 and ratio 0:
  - o_ratio_err pulses once per load.
  - o_ratio_active is unchanged and comb timing is undisturbed.
- i_enable dropped at dec_cnt = 30:
  - Next cycle all strobes are 0 and o_running = 0.
  - After re-enable, the count restarts from 0 and warm-up repeats (3 comb_ce without valid).
- Ratio 2, strobe every cycle: o_comb_ce alternates 0/1 every cycle; o_out_valid follows each comb_ce by 1 cycle once in RUN.
- Async i_reset asserted mid-cycle during RUN: all outputs drop to 0 immediately and o_ratio_active = 64.

Source files
------------

// File: rtl/cic_decim_sequencer.sv
// Clock-enable sequencer for the 1-bit SDR CIC decimator: integrator/comb enables,
// boundary-aligned decimation-ratio changes and comb-pipeline warm-up gating of o_out_valid.
//
// state  | meaning
// IDLE   | chain held, no enables issued
// WARM   | enables issued, comb pipeline still flushing, o_out_valid suppressed
// RUN    | enables issued, o_out_valid raised on each decimated output
module cic_decim_sequencer #(
    parameter int RW            = 12,
    parameter int N_STAGES      = 3,
    parameter int DEFAULT_RATIO = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_sample_valid,
    input  logic [RW-1:0] i_ratio,
    input  logic          i_ratio_load,
    output logic          o_int_ce,
    output logic          o_comb_ce,
    output logic          o_out_valid,
    output logic [RW-1:0] o_ratio_active,
    output logic          o_ratio_err,
    output logic          o_running
);

    localparam int WW = $clog2(N_STAGES + 1);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_WARM = 2'd1;
    localparam logic [1:0]    S_RUN  = 2'd2;

    localparam logic [WW-1:0] WARM_INIT = WW'(N_STAGES);
    localparam logic [RW-1:0] RATIO_RST = RW'(DEFAULT_RATIO);

    logic [1:0]    r_state;
    logic [RW-1:0] r_dec_cnt;
    logic [WW-1:0] r_warm_cnt;
    logic [RW-1:0] r_ratio;
    logic [RW-1:0] r_pend;
    logic          r_pend_v;
    logic          r_int_ce;
    logic          r_comb_ce;
    logic          r_comb_run;
    logic          r_out_valid;
    logic          r_ratio_err;

    logic w_accept;
    logic w_wrap;
    logic w_load_ok;
    logic w_load_bad;
    logic w_apply;

    assign w_accept   = i_enable & i_sample_valid & (r_state != S_IDLE);
    assign w_wrap     = w_accept & (r_dec_cnt == (r_ratio - RW'(1)));
    assign w_load_ok  = i_ratio_load & (i_ratio >= RW'(2));
    assign w_load_bad = i_ratio_load & (i_ratio < RW'(2));
    assign w_apply    = w_wrap & r_pend_v;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_dec_cnt   <= '0;
            r_warm_cnt  <= WARM_INIT;
            r_int_ce    <= 1'b0;
            r_comb_ce   <= 1'b0;
            r_comb_run  <= 1'b0;
            r_out_valid <= 1'b0;
            r_ratio_err <= 1'b0;
        end else begin
            r_ratio_err <= w_load_bad;
            if (!i_enable) begin
                r_state     <= S_IDLE;
                r_dec_cnt   <= '0;
                r_int_ce    <= 1'b0;
                r_comb_ce   <= 1'b0;
                r_comb_run  <= 1'b0;
                r_out_valid <= 1'b0;
            end else if (r_state == S_IDLE) begin
                r_state     <= S_WARM;
                r_warm_cnt  <= WARM_INIT;
                r_dec_cnt   <= '0;
                r_int_ce    <= 1'b0;
                r_comb_ce   <= 1'b0;
                r_comb_run  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_int_ce    <= i_sample_valid;
                r_comb_ce   <= w_wrap;
                // remember whether this boundary belongs to RUN, so the WARM->RUN comb_ce stays invalid
                r_comb_run  <= w_wrap & (r_state == S_RUN);
                r_out_valid <= r_comb_ce & r_comb_run;
                if (w_accept) begin
                    r_dec_cnt <= w_wrap ? '0 : r_dec_cnt + RW'(1);
                end
                if (w_apply) begin
                    r_state    <= S_WARM;
                    r_warm_cnt <= WARM_INIT;
                end else if (w_wrap && (r_state == S_WARM)) begin
                    if (r_warm_cnt == WW'(1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_warm_cnt <= r_warm_cnt - WW'(1);
                    end
                end
            end
        end
    end

    // In IDLE a load takes effect at once; otherwise it waits for the next wrap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ratio  <= RATIO_RST;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_load_ok) begin
                r_ratio  <= i_ratio;
                r_pend_v <= 1'b0;
            end else if (r_pend_v) begin
                r_ratio  <= r_pend;
                r_pend_v <= 1'b0;
            end
        end else begin
            if (w_apply) begin
                r_ratio  <= r_pend;
                r_pend_v <= 1'b0;
            end
            if (w_load_ok) begin
                r_pend   <= i_ratio;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign o_int_ce       = r_int_ce;
    assign o_comb_ce      = r_comb_ce;
    assign o_out_valid    = r_out_valid;
    assign o_ratio_active = r_ratio;
    assign o_ratio_err    = r_ratio_err;
    assign o_running      = (r_state == S_RUN);

endmodule
